// File: rtl/bsmm_pkg.sv
// Shared constants and types for the bit-serial matrix multiply operand path.
package bsmm_pkg;

  localparam int unsigned NUM_VALUES   = 10;
  localparam int unsigned NUM_RESULTS  = 15;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned MULT_LATENCY = 64;

  typedef logic [WORD_W-1:0]                  word_t;
  typedef logic [NUM_VALUES-1:0][WORD_W-1:0]  values_t;

  typedef enum logic [1:0] {
    FILL,
    FIRE,
    WAIT
  } loader_state_t;

endpackage

// File: rtl/bsmm_operand_loader.sv
// Collects a frame of operand words, launches the multiplier and holds the
// operands stable until the multiplier result is valid.
module bsmm_operand_loader
  import bsmm_pkg::*;
#(
  parameter int unsigned NUM_VALUES   = bsmm_pkg::NUM_VALUES,
  parameter int unsigned WORD_W       = bsmm_pkg::WORD_W,
  parameter int unsigned MULT_LATENCY = bsmm_pkg::MULT_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WORD_W-1:0]                  in_data,
  input  logic                               in_last,
  output logic [NUM_VALUES-1:0][WORD_W-1:0]  values,
  output logic                               start,
  output logic                               busy,
  output logic                               result_valid,
  output logic                               frame_error
);

  localparam int unsigned IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
  localparam int unsigned CNT_W = $clog2(MULT_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 1);

  loader_state_t                      state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [NUM_VALUES-1:0][WORD_W-1:0]  values_q, values_d;
  logic                               err_q, err_d;
  logic                               accept;
  logic                               frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= '0;
      cnt_q    <= '0;
      values_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      values_q <= values_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    values_d  = values_q;
    err_d     = err_q;
    accept    = in_valid && (state_q == FILL);
    frame_end = accept && (in_last || (idx_q == LAST_IDX));
    case (state_q)
      FILL: begin
        if (accept) begin
          // An early in_last zeroes every slot above the word just written.
          for (int unsigned i = 0; i < NUM_VALUES; i++) begin
            if (i == 32'(idx_q)) begin
              values_d[i] = in_data;
            end else if (in_last && (i > 32'(idx_q))) begin
              values_d[i] = '0;
            end
          end
          if (frame_end) begin
            idx_d   = '0;
            err_d   = !in_last;
            state_d = FIRE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FIRE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          err_d   = 1'b0;
          state_d = FILL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready     = !rst && (state_q == FILL);
    start        = !rst && (state_q == FIRE);
    busy         = !rst && ((state_q == FIRE) || (state_q == WAIT));
    result_valid = !rst && (state_q == WAIT) && (cnt_q == '0);
    frame_error  = start && err_q;
    values       = values_q;
  end

endmodule

// File: tb/tb_bsmm_operand_loader.sv
// Randomised and directed bench for bsmm_operand_loader against a timing/frame model.
module tb_bsmm_operand_loader;
  import bsmm_pkg::*;

  localparam int N = NUM_VALUES;
  localparam int L = MULT_LATENCY;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last;
  logic [WORD_W-1:0] in_data;
  logic [NUM_VALUES-1:0][WORD_W-1:0] values;
  logic start, busy, result_valid, frame_error;

  bsmm_operand_loader #(.NUM_VALUES(NUM_VALUES), .WORD_W(WORD_W), .MULT_LATENCY(MULT_LATENCY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .values(values), .start(start), .busy(busy),
    .result_valid(result_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: frame contents plus the launch/result cycle window of the last frame.
  logic [WORD_W-1:0] m_vals [N];
  int m_idx = 0;
  int fire_c = -1;
  int res_c = -1;
  bit m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_window(int c);
    return (c >= fire_c) && (c <= res_c);
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < N; i++) m_vals[i] = '0;
      m_idx = 0; fire_c = -1; res_c = -1; m_err = 0;
    end else if (in_valid && !in_window(cyc)) begin
      m_vals[m_idx] = in_data;
      if (in_last || m_idx == N - 1) begin
        if (in_last) for (int j = m_idx + 1; j < N; j++) m_vals[j] = '0;
        m_err = !in_last;
        fire_c = cyc + 1;
        res_c = cyc + 1 + L;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic compare_outputs();
    bit exp_start;
    exp_start = !rst && (cyc == fire_c);
    check("in_ready", 64'(in_ready), 64'(!rst && !in_window(cyc)));
    check("start", 64'(start), 64'(exp_start));
    check("busy", 64'(busy), 64'(!rst && in_window(cyc)));
    check("result_valid", 64'(result_valid), 64'(!rst && cyc == res_c));
    check("frame_error", 64'(frame_error), 64'(exp_start && m_err));
    for (int i = 0; i < N; i++) check("values", 64'(values[i]), 64'(m_vals[i]));
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input logic last);
    bit r;
    int t;
    in_valid = 1'b1; in_data = d; in_last = last;
    t = 0;
    forever begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      t++;
      if (t > 300) begin check("send_timeout", 64'(t), 64'(0)); break; end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Counts cycles after the current one until result_valid is seen at a negedge.
  task automatic wait_rv(output int k);
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!result_valid && k < L + 20);
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < L + 20) begin @(negedge clk); t++; end
    check("ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic stimulus();
    int k, len, gap;
    int sig [10] = '{1, 3, 5, 19, 24, 12, 23, 135, -23, 20};
    logic [NUM_VALUES-1:0][WORD_W-1:0] exp_v;

    // Reset held 3 cycles with in_valid high.
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd55; in_last = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'(1));
    check("post_rst_values", 64'(values == '0), 64'(1));
    @(posedge clk); #1;

    // Full frame, then back-pressure during the wait.
    for (int i = 0; i < 10; i++) send_word(WORD_W'(sig[i]), i == 9);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("full_start", 64'(start), 64'(1));
    check("full_ferr", 64'(frame_error), 64'(0));
    check("full_v8", 64'(values[8]), 64'h0000_0000_FFFF_FFE9);
    in_valid = 1'b1; in_data = 32'd77; in_last = 1'b1;
    wait_rv(k);
    check("full_latency", 64'(k), 64'(L));
    check("bp_v0_held", 64'(values[0]), 64'(1));
    @(negedge clk);
    check("bp_ready_fill", 64'(in_ready), 64'(1));
    check("bp_v8_held", 64'(values[8]), 64'h0000_0000_FFFF_FFE9);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("bp_v0_new", 64'(values[0]), 64'(77));
    check("bp_v1_clr", 64'(values[1]), 64'(0));
    wait_ready();

    // Short frame.
    send_word(32'd7, 1'b0); send_word(32'd8, 1'b0); send_word(32'd9, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    exp_v = '0; exp_v[0] = 32'd7; exp_v[1] = 32'd8; exp_v[2] = 32'd9;
    check("short_start", 64'(start), 64'(1));
    check("short_ferr", 64'(frame_error), 64'(0));
    check("short_vals", 64'(values == exp_v), 64'(1));
    wait_ready();

    // Ten words without in_last.
    for (int i = 0; i < 10; i++) send_word(WORD_W'(100 + i), 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("miss_start", 64'(start), 64'(1));
    check("miss_ferr", 64'(frame_error), 64'(1));
    send_word(32'd999, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("miss_11th_v0", 64'(values[0]), 64'(999));
    check("miss_11th_v9", 64'(values[9]), 64'(109));
    send_word(32'd5, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_ready();

    // Reset two cycles after start.
    send_word(32'd11, 1'b0); send_word(32'd12, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("rw_start", 64'(start), 64'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rw_busy", 64'(busy), 64'(0));
    check("rw_values", 64'(values == '0), 64'(1));
    check("rw_ready", 64'(in_ready), 64'(1));
    k = 0;
    repeat (L + 5) begin @(negedge clk); if (result_valid) k++; end
    check("rw_no_rv", 64'(k), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_word(WORD_W'(40 + i), i == 3);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("rw_new_start", 64'(start), 64'(1));
    wait_rv(k);
    check("rw_new_latency", 64'(k), 64'(L));
    @(posedge clk); #1;

    // Randomised frames with gaps and arbitrary in_last placement.
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 12);
      for (int w = 0; w < len; w++) begin
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
        send_word($urandom, (w == len - 1) ? 1'b1 : ($urandom_range(0, 7) == 0));
      end
      idle($urandom_range(0, 3));
    end
    idle(L + 5);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    for (int i = 0; i < N; i++) m_vals[i] = '0;
    fork
      forever begin @(posedge clk); model_step(); cyc++; end
      forever begin @(negedge clk); if (cyc > 0) compare_outputs(); end
      stimulus();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
